// File: rtl/score_pkg.sv
// Shared types and constants for the score tracker and the HUD digit decoders.
package score_pkg;

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  typedef logic [3:0]  bcd_digit_t;
  typedef logic [15:0] bcd4_t;

  localparam bcd4_t      BCD_MAX   = 16'h9999;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a} patterns for digits 0..9.
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000
  };

endpackage

// File: rtl/score_tracker_7seg_if.sv
// Game-event inputs and score/display outputs of the score tracker.
interface score_tracker_7seg_if;
  import score_pkg::*;

  logic       game_start;
  logic       score_tick;
  logic       game_over;
  logic       show_hs;
  bcd4_t      score_bcd;
  bcd4_t      hscore_bcd;
  logic       running;
  logic       new_high;
  logic [3:0] an;
  logic [6:0] seg;

  modport master (
    output game_start, score_tick, game_over, show_hs,
    input  score_bcd, hscore_bcd, running, new_high, an, seg
  );

  modport slave (
    input  game_start, score_tick, game_over, show_hs,
    output score_bcd, hscore_bcd, running, new_high, an, seg
  );

endinterface

// File: rtl/seg7_decode.sv
// BCD digit to active-low 7-segment pattern; non-decimal nibbles and blank go dark.
module seg7_decode
  import score_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank && digit <= 4'd9) begin
      seg = SEG_DIGIT[digit];
    end
  end

endmodule

// File: rtl/score_tracker_7seg.sv
// Run score / persistent high score keeper with a multiplexed 4-digit 7-seg scan.
module score_tracker_7seg
  import score_pkg::*;
#(
  parameter int SCAN_DIV      = 50000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  score_tracker_7seg_if.slave  bus
);

  localparam int               CNT_W    = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  // Ripple BCD increment that sticks at 9999 instead of wrapping.
  function automatic bcd4_t bcd_inc_sat(input bcd4_t v);
    bcd4_t r;
    logic  carry;
    r     = v;
    carry = 1'b1;
    if (v != BCD_MAX) begin
      for (int k = 0; k < 4; k++) begin
        if (carry) begin
          if (r[4*k +: 4] == 4'd9) begin
            r[4*k +: 4] = 4'd0;
          end else begin
            r[4*k +: 4] = r[4*k +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  state_t           state, state_nxt;
  bcd4_t            score, score_nxt;
  bcd4_t            hscore, hscore_nxt;
  bcd4_t            final_score;
  logic             new_high, new_high_nxt;
  logic [CNT_W-1:0] scan_cnt;
  logic [1:0]       idx, idx_nxt;
  logic [3:0]       an;
  logic [6:0]       seg, seg_nxt;
  bcd4_t            src;
  bcd_digit_t       dig;
  logic             blank;
  logic             wrap;

  always_comb begin
    state_nxt    = state;
    score_nxt    = score;
    hscore_nxt   = hscore;
    new_high_nxt = new_high;
    final_score  = bus.score_tick ? bcd_inc_sat(score) : score;
    case (state)
      RUN: begin
        score_nxt = final_score;
        // game_over takes priority over a coincident game_start.
        if (bus.game_over) begin
          state_nxt = OVER;
          if (final_score > hscore) begin
            hscore_nxt   = final_score;
            new_high_nxt = 1'b1;
          end
        end
      end
      default: begin
        if (bus.game_start) begin
          state_nxt    = RUN;
          score_nxt    = '0;
          new_high_nxt = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      score    <= '0;
      hscore   <= '0;
      new_high <= 1'b0;
    end else begin
      state    <= state_nxt;
      score    <= score_nxt;
      hscore   <= hscore_nxt;
      new_high <= new_high_nxt;
    end
  end

  // Pattern for the digit about to be shown; registered on the scan wrap.
  always_comb begin
    wrap    = (scan_cnt == CNT_LAST);
    idx_nxt = idx - 2'd1;
    src     = bus.show_hs ? hscore : score;
    dig     = src[3:0];
    blank   = 1'b0;
    case (idx_nxt)
      2'd3: begin dig = src[15:12]; blank = BLANK_LEADING && (src[15:12] == 4'h0);  end
      2'd2: begin dig = src[11:8];  blank = BLANK_LEADING && (src[15:8]  == 8'h0);  end
      2'd1: begin dig = src[7:4];   blank = BLANK_LEADING && (src[15:4]  == 12'h0); end
      default: begin dig = src[3:0]; blank = 1'b0; end
    endcase
  end

  seg7_decode u_seg7_decode (
    .digit (dig),
    .blank (blank),
    .seg   (seg_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= 2'd3;
      an       <= 4'b1111;
      seg      <= SEG_BLANK;
    end else if (wrap) begin
      scan_cnt <= '0;
      idx      <= idx_nxt;
      an       <= ~(4'b0001 << idx_nxt);
      seg      <= seg_nxt;
    end else begin
      scan_cnt <= scan_cnt + CNT_W'(1);
    end
  end

  assign bus.score_bcd  = score;
  assign bus.hscore_bcd = hscore;
  assign bus.running    = (state == RUN);
  assign bus.new_high   = new_high;
  assign bus.an         = an;
  assign bus.seg        = seg;

endmodule

// File: tb/tb_score_tracker_7seg.sv
// Bench for score_tracker_7seg: directed scenarios plus random events against an integer model.
module tb_score_tracker_7seg;

  localparam int SD = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  score_tracker_7seg_if bus();

  score_tracker_7seg #(.SCAN_DIV(SD), .BLANK_LEADING(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state: plain integers, state 0=idle 1=run 2=over.
  int         m_state = 0;
  int         m_score = 0;
  int         m_hs    = 0;
  bit         m_nh    = 1'b0;
  int         m_cnt   = 0;
  int         m_idx   = 3;
  logic [3:0] m_an    = 4'hF;
  logic [6:0] m_seg   = 7'h7F;

  logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};
  int p10 [4] = '{1, 10, 100, 1000};

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    int val;
    if (!rst_n) begin
      m_state = 0; m_score = 0; m_hs = 0; m_nh = 1'b0;
      m_cnt = 0; m_idx = 3; m_an = 4'hF; m_seg = 7'h7F;
    end else begin
      if (m_cnt == SD - 1) begin
        m_cnt = 0;
        m_idx = (m_idx + 3) % 4;
        val   = bus.show_hs ? m_hs : m_score;
        m_an  = ~(4'b0001 << m_idx);
        m_seg = (m_idx > 0 && val < p10[m_idx]) ? 7'h7F : seg_tbl[(val / p10[m_idx]) % 10];
      end else begin
        m_cnt++;
      end
      if (m_state == 1) begin
        if (bus.score_tick && m_score < 9999) m_score++;
        if (bus.game_over) begin
          m_state = 2;
          if (m_score > m_hs) begin
            m_hs = m_score;
            m_nh = 1'b1;
          end
        end
      end else if (bus.game_start) begin
        m_state = 1;
        m_score = 0;
        m_nh    = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("score",    bus.score_bcd,  to_bcd(m_score));
      check("hscore",   bus.hscore_bcd, to_bcd(m_hs));
      check("running",  16'(bus.running),  16'(m_state == 1));
      check("new_high", 16'(bus.new_high), 16'(m_nh));
      check("an",       16'(bus.an),  16'(m_an));
      check("seg",      16'(bus.seg), 16'(m_seg));
    end
  end

  task automatic cyc(input bit st, input bit tk, input bit go);
    @(negedge clk);
    bus.game_start = st;
    bus.score_tick = tk;
    bus.game_over  = go;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_score"},  bus.score_bcd,  16'h0000);
    check({tag, "_hscore"}, bus.hscore_bcd, 16'h0000);
    check({tag, "_run"},    16'(bus.running),  16'h0);
    check({tag, "_nh"},     16'(bus.new_high), 16'h0);
    check({tag, "_an"},     16'(bus.an),  16'h000F);
    check({tag, "_seg"},    16'(bus.seg), 16'h007F);
  endtask

  logic [3:0] exp_an  [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
  logic [6:0] exp_seg [4] = '{7'b1111111, 7'b1111111, 7'b0011001, 7'b0100100};

  initial begin
    bit         found;
    logic [3:0] prev;
    bus.game_start = 1'b0;
    bus.score_tick = 1'b0;
    bus.game_over  = 1'b0;
    bus.show_hs    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    check_reset_vals("reset");

    // Ticks while idle are ignored; anodes stay off until the first wrap.
    repeat (3) cyc(0, 1, 0);
    check("idle_an", 16'(bus.an), 16'h000F);
    repeat (9) cyc(0, 1, 0);
    cyc(0, 0, 0);
    check("idle_score", bus.score_bcd, 16'h0000);
    check("idle_run",   16'(bus.running), 16'h0);

    cyc(1, 0, 0);
    repeat (137) cyc(0, 1, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    check("run1_score", bus.score_bcd,  16'h0137);
    check("run1_hs",    bus.hscore_bcd, 16'h0137);
    check("run1_nh",    16'(bus.new_high), 16'h1);
    check("run1_over",  16'(bus.running),  16'h0);

    cyc(1, 0, 0);
    cyc(0, 0, 0);
    check("run2_start_nh",    16'(bus.new_high), 16'h0);
    check("run2_start_score", bus.score_bcd, 16'h0000);
    check("run2_start_run",   16'(bus.running), 16'h1);
    repeat (99) cyc(0, 1, 0);
    cyc(0, 1, 1);
    cyc(0, 0, 0);
    check("run2_score", bus.score_bcd,  16'h0100);
    check("run2_hs",    bus.hscore_bcd, 16'h0137);
    check("run2_nh",    16'(bus.new_high), 16'h0);

    cyc(1, 0, 0);
    repeat (5) cyc(0, 1, 0);
    cyc(0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_vals("midrst");

    cyc(1, 0, 0);
    repeat (9998) cyc(0, 1, 0);
    cyc(0, 0, 0);
    check("sat_9998", bus.score_bcd, 16'h9998);
    repeat (3) cyc(0, 1, 0);
    cyc(0, 0, 0);
    check("sat_9999", bus.score_bcd, 16'h9999);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    check("sat_hs", bus.hscore_bcd, 16'h9999);
    check("sat_nh", 16'(bus.new_high), 16'h1);

    // Scan of score 0042 with leading-zero blanking.
    cyc(1, 0, 0);
    repeat (42) cyc(0, 1, 0);
    cyc(0, 0, 0);
    check("scan_score", bus.score_bcd, 16'h0042);
    found = 1'b0;
    prev  = bus.an;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.an == 4'b0111 && prev != 4'b0111) found = 1'b1;
      prev = bus.an;
    end
    check("scan_align", 16'(found), 16'h1);
    if (found) begin
      for (int d = 0; d < 4; d++) begin
        for (int c = 0; c < SD; c++) begin
          if (d != 0 || c != 0) @(negedge clk);
          check("scan_an",  16'(bus.an),  16'(exp_an[d]));
          check("scan_seg", 16'(bus.seg), 16'(exp_seg[d]));
        end
      end
    end

    repeat (3000) begin
      @(negedge clk);
      rst_n          = ($urandom % 400) != 0;
      bus.game_start = ($urandom % 25) == 0;
      bus.score_tick = ($urandom % 3) != 0;
      bus.game_over  = ($urandom % 40) == 0;
      if (($urandom % 16) == 0) bus.show_hs = ~bus.show_hs;
    end

    cyc(0, 0, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
